pwd_fetch_host: RTL

Initiator side of the UART password protocol. Issues single-byte commands (`g`, `t`, ESC) to a remote board through the FPGA's byte-level UART transmitter. For `g`, it collects the 16-byte password reply from the UART receiver into an internal buffer that the surrounding logic reads. It sits between the top-level control logic and the `uart_tx_sol`/`uart_rx_sol` instances that drive the link to the gold board.

---
 rtl/pwd_pkg.sv | 38 +++
 rtl/pwd_gap_timer.sv | 31 +++
 rtl/pwd_fetch_host.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pwd_pkg.sv
// pwd_pkg: shared definitions for the UART password fetch host.
//   - opcode bytes sent to the remote board
//   - cmd encodings and FSM state enum
//   - cmd_opcode(): maps a command to its opcode byte
package pwd_pkg;

    localparam int unsigned PWD_NBYTES = 16;

    localparam logic [7:0] OP_GET    = 8'h67;  // 'g'
    localparam logic [7:0] OP_TOGGLE = 8'h74;  // 't'
    localparam logic [7:0] OP_RESET  = 8'h1B;  // ESC

    typedef enum logic [1:0] {
        CMD_GET    = 2'd0,
        CMD_TOGGLE = 2'd1,
        CMD_RESET  = 2'd2,
        CMD_RSVD   = 2'd3
    } pwd_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_FIN
    } pwd_state_e;

    function automatic logic [7:0] cmd_opcode(input pwd_cmd_e c);
        logic [7:0] op;
        case (c)
            CMD_GET:    op = OP_GET;
            CMD_TOGGLE: op = OP_TOGGLE;
            CMD_RESET:  op = OP_RESET;
            default:    op = 8'h00;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pwd_gap_timer.sv
// pwd_gap_timer: idle-gap counter for reply bytes.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear the count (RECV entry / each received byte)
//   run       - count this cycle
//   expired   - count has reached LIMIT-1
module pwd_gap_timer #(
    parameter int unsigned LIMIT = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam logic [17:0] LAST = 18'(LIMIT - 1);

    logic [17:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 18'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/pwd_fetch_host.sv
// pwd_fetch_host: initiator side of the UART password protocol.
// Sends a single opcode byte ('g', 't', ESC) through the UART transmitter;
// for 'g' collects an NBYTES reply into a buffer read via rd_addr/rd_data.
// Optional feature: define PWD_FETCH_TIMEOUT_EN to abort RECV with err after
// TIMEOUT_CYCLES idle cycles between reply bytes.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start, cmd         - transaction request and operation (sampled in IDLE)
//   tx_en, tx_data     - strobe/byte to UART transmitter; tx_rdy from it
//   rx_valid, rx_data  - byte strobe/data from UART receiver
//   rd_addr, rd_data   - combinational buffer read port
//   busy, done, err    - status: not idle, end strobe, sticky error
module pwd_fetch_host
    import pwd_pkg::*;
#(
    parameter int unsigned NBYTES         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    pwd_state_e state, next_state;
    pwd_cmd_e   cmd_q;
    logic [4:0] cnt;
    logic       err_q;
    logic       done_q;
    logic [7:0] mem [PWD_NBYTES];

    logic latch_cmd;
    logic set_err;
    logic clr_err;
    logic buf_we;
    logic timeout_hit;

`ifdef PWD_FETCH_TIMEOUT_EN
    logic gap_clr;
    logic gap_run;

    // Holding clear outside RECV covers the clear-on-entry case.
    assign gap_clr = (state != ST_RECV) || rx_valid;
    assign gap_run = (state == ST_RECV);

    pwd_gap_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (gap_clr),
        .run    (gap_run),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tx_en      = 1'b0;
        tx_data    = '0;
        latch_cmd  = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        buf_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    latch_cmd = 1'b1;
                    clr_err   = 1'b1;
                    if (pwd_cmd_e'(cmd) == CMD_RSVD) begin
                        set_err    = 1'b1;
                        next_state = ST_FIN;
                    end else begin
                        next_state = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (tx_rdy) begin
                    tx_en      = 1'b1;
                    tx_data    = cmd_opcode(cmd_q);
                    next_state = (cmd_q == CMD_GET) ? ST_RECV : ST_FIN;
                end
            end
            ST_RECV: begin
                // A byte arriving on the expiry cycle takes priority.
                if (rx_valid) begin
                    buf_we = 1'b1;
                    if (cnt == 5'(NBYTES - 1)) begin
                        next_state = ST_FIN;
                    end
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                // Two cycles: first arms done_q, second presents it and exits.
                if (done_q) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q  <= CMD_GET;
            cnt    <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < PWD_NBYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (latch_cmd) begin
                cmd_q <= pwd_cmd_e'(cmd);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
            if (state == ST_SEND) begin
                cnt <= '0;
            end else if (buf_we) begin
                mem[cnt[3:0]] <= rx_data;
                cnt           <= cnt + 5'd1;
            end
            done_q <= (state == ST_FIN) && !done_q;
        end
    end

    assign rd_data = mem[rd_addr];
    assign busy    = (state != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule
